// File: rtl/alu_seq.sv
// Registered ALU for the execute stage: single-cycle logic/arithmetic ops plus
// iterative unsigned multiply (shift-add) and divide/remainder (restoring).
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl_in,
    output logic             ready,
    output logic             valid_out,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           op_sel;   // [1]: divide, [0]: take upper half of acc
    logic [WIDTH-1:0]     opnd;     // multiplicand for MUL*, divisor for DIV*/REM*
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_diff;

    // Returns {zero, result} for the single-cycle op set.
    function automatic logic [WIDTH:0] alu_single(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic lt;
        lt = (a < b);
        case (op)
            4'b0000: alu_single = {1'b0, a & b};
            4'b0001: alu_single = {1'b0, a | b};
            4'b0010: alu_single = {1'b0, a + b};
            4'b0110: alu_single = {(a == b), a - b};
            4'b0111: alu_single = {lt, {(WIDTH-1){1'b0}}, lt};
            4'b1100: alu_single = {1'b0, ~(a | b)};
            default: alu_single = {1'b0, a};
        endcase
    endfunction

    // Multiply keeps {partial sum, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        acc_next = acc;
        if (op_sel[1]) begin
            if (div_diff[WIDTH])
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ready      <= 1'b1;
            valid_out  <= 1'b0;
            ALU_result <= '0;
            zero       <= 1'b0;
            cnt        <= '0;
            op_sel     <= '0;
            opnd       <= '0;
            acc        <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        if (ALUControl_in[3:2] == 2'b10) begin
                            op_sel <= ALUControl_in[1:0];
                            opnd   <= ALUControl_in[1] ? B : A;
                            acc    <= {{WIDTH{1'b0}}, (ALUControl_in[1] ? A : B)};
                            cnt    <= '0;
                            state  <= BUSY;
                        end else begin
                            {zero, ALU_result} <= alu_single(ALUControl_in, A, B);
                            valid_out          <= 1'b1;
                            state              <= DONE;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        ALU_result <= op_sel[0] ? acc_next[2*WIDTH-1:WIDTH]
                                                : acc_next[WIDTH-1:0];
                        zero       <= 1'b0;
                        valid_out  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [31:0] A32 = '0, B32 = '0;
    logic [7:0]  A8 = '0, B8 = '0;
    logic [3:0]  op32 = '0, op8 = '0;
    logic        ready32, valid32, zero32, ready8, valid8, zero8;
    logic [31:0] res32;
    logic [7:0]  res8;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .A(A32), .B(B32),
        .ALUControl_in(op32), .ready(ready32), .valid_out(valid32),
        .ALU_result(res32), .zero(zero32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .A(A8), .B(B8),
        .ALUControl_in(op8), .ready(ready8), .valid_out(valid8),
        .ALU_result(res8), .zero(zero8)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    bit          sel8 = 1'b0;
    logic        cur_valid, cur_ready, cur_zero;
    logic [31:0] cur_res;
    assign cur_valid = sel8 ? valid8 : valid32;
    assign cur_ready = sel8 ? ready8 : ready32;
    assign cur_zero  = sel8 ? zero8  : zero32;
    assign cur_res   = sel8 ? {24'h0, res8} : res32;

    int          obs_lat;
    logic [31:0] obs_res;
    logic        obs_zero, obs_vld_after, obs_rdy_after;

    // Reference model using native wide arithmetic.
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint unsigned mask, ua, ub, p, r;
        mask = (w == 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
        ua = {32'h0, a} & mask;
        ub = {32'h0, b} & mask;
        p  = ua * ub;
        e.zero = 1'b0;
        e.lat  = 1;
        case (op)
            4'b0000: r = ua & ub;
            4'b0001: r = ua | ub;
            4'b0010: r = (ua + ub) & mask;
            4'b0110: begin r = (ua - ub) & mask; e.zero = (ua == ub); end
            4'b0111: begin r = (ua < ub) ? 64'd1 : 64'd0; e.zero = (ua < ub); end
            4'b1100: r = ~(ua | ub) & mask;
            4'b1000: begin r = p & mask; e.lat = w + 1; end
            4'b1001: begin r = (p >> w) & mask; e.lat = w + 1; end
            4'b1010: begin r = (ub == 0) ? mask : ua / ub; e.lat = w + 1; end
            4'b1011: begin r = (ub == 0) ? ua : ua % ub; e.lat = w + 1; end
            default: r = ua;
        endcase
        e.res = r[31:0];
        return e;
    endfunction

    // Issue one op, push its expectation, collect what the DUT returns.
    task automatic run_op(input bit w8, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input bit noise);
        sel8 = w8;
        @(negedge clk);
        if (w8) begin
            A8 = a[7:0]; B8 = b[7:0]; op8 = op; start8 = 1'b1;
        end else begin
            A32 = a; B32 = b; op32 = op; start32 = 1'b1;
        end
        sb.push_back(model(w8 ? 8 : 32, op, a, b));
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        obs_lat = 1;
        while (!cur_valid && obs_lat < 100) begin
            if (noise) begin
                start32 = 1'b1;
                A32 = $urandom; B32 = $urandom;
                op32 = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
            start32 = 1'b0;
            obs_lat++;
        end
        obs_res  = cur_res;
        obs_zero = cur_zero;
        @(posedge clk); #1;
        obs_vld_after = cur_valid;
        obs_rdy_after = cur_ready;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (ready32 !== 1'b1 || valid32 !== 1'b0 || res32 !== 32'h0 || zero32 !== 1'b0 ||
            ready8 !== 1'b1 || valid8 !== 1'b0 || res8 !== 8'h0 || zero8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b/%b vld=%b/%b res=%h/%h zero=%b/%b, want rdy=1 vld=0 res=0 zero=0",
                     ready32, ready8, valid32, valid8, res32, res8, zero32, zero8);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0]  ops[10] = '{4'b0010, 4'b0110, 4'b0110, 4'b0111, 4'b1111,
                                 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0011};
        logic [31:0] as[10]  = '{32'd5, 32'd9, 32'd3, 32'd3, 32'hABCD,
                                 32'hF0F0_1234, 32'hF0F0_0000, 32'h1234_0000, 32'd5, 32'h55};
        logic [31:0] bs[10]  = '{32'd7, 32'd9, 32'd5, 32'd5, 32'h1111,
                                 32'hFF00_FF00, 32'h0000_0F0F, 32'h0000_5678, 32'd3, 32'h99};
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, ops[i], as[i], bs[i], 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs_res !== e.res || obs_zero !== e.zero || obs_lat != e.lat ||
                obs_vld_after !== 1'b0 || obs_rdy_after !== 1'b1) begin
                n_fail++;
                $display("FAIL single_op%0d op=%b: got res=%h zero=%b lat=%0d vld_next=%b rdy_next=%b, want res=%h zero=%b lat=%0d vld_next=0 rdy_next=1",
                         i, ops[i], obs_res, obs_zero, obs_lat, obs_vld_after, obs_rdy_after,
                         e.res, e.zero, e.lat);
            end
        end
    endtask

    task automatic test_multi();
        logic [3:0]  ops[8]  = '{4'b1000, 4'b1001, 4'b1010, 4'b1011,
                                 4'b1010, 4'b1011, 4'b1000, 4'b1001};
        logic [31:0] as[8]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                                 32'd5, 32'd5, 32'd0, 32'hDEAD_BEEF};
        logic [31:0] bs[8]   = '{32'd2, 32'd2, 32'd7, 32'd7,
                                 32'd0, 32'd0, 32'h1234_5678, 32'hCAFE_F00D};
        bit          nz[8]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, ops[i], as[i], bs[i], nz[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs_res !== e.res || obs_zero !== e.zero || obs_lat != e.lat ||
                obs_vld_after !== 1'b0 || obs_rdy_after !== 1'b1) begin
                n_fail++;
                $display("FAIL multi_op%0d op=%b: got res=%h zero=%b lat=%0d vld_next=%b rdy_next=%b, want res=%h zero=%b lat=%0d vld_next=0 rdy_next=1",
                         i, ops[i], obs_res, obs_zero, obs_lat, obs_vld_after, obs_rdy_after,
                         e.res, e.zero, e.lat);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int   pulses = 0;
        exp_t e;
        sel8 = 1'b0;
        @(negedge clk);
        A32 = 32'd100; B32 = 32'd7; op32 = 4'b1010; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (ready32 !== 1'b1 || valid32 !== 1'b0 || res32 !== 32'h0 || zero32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got rdy=%b vld=%b res=%h zero=%b, want rdy=1 vld=0 res=0 zero=0",
                     ready32, valid32, res32, zero32);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid32 === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL no_valid_after_abort: got %0d valid pulses, want 0", pulses);
        end
        run_op(1'b0, 4'b0010, 32'd1, 32'd1, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (obs_res !== e.res || obs_zero !== e.zero || obs_lat != e.lat || obs_rdy_after !== 1'b1) begin
            n_fail++;
            $display("FAIL add_after_reset: got res=%h zero=%b lat=%0d rdy_next=%b, want res=%h zero=%b lat=%0d rdy_next=1",
                     obs_res, obs_zero, obs_lat, obs_rdy_after, e.res, e.zero, e.lat);
        end
    endtask

    task automatic test_width8();
        logic [3:0]  ops[5] = '{4'b1001, 4'b1010, 4'b1000, 4'b1011, 4'b0110};
        logic [31:0] as[5]  = '{32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'h10};
        logic [31:0] bs[5]  = '{32'hFF, 32'h10, 32'hFF, 32'h10, 32'h10};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, ops[i], as[i], bs[i], 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs_res !== e.res || obs_zero !== e.zero || obs_lat != e.lat ||
                obs_vld_after !== 1'b0 || obs_rdy_after !== 1'b1) begin
                n_fail++;
                $display("FAIL w8_op%0d op=%b: got res=%h zero=%b lat=%0d vld_next=%b rdy_next=%b, want res=%h zero=%b lat=%0d vld_next=0 rdy_next=1",
                         i, ops[i], obs_res, obs_zero, obs_lat, obs_vld_after, obs_rdy_after,
                         e.res, e.zero, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] codes[12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                                  4'b0011, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0101};
        logic [3:0]  op;
        logic [31:0] a, b;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            op = codes[$urandom_range(0, 11)];
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            if (i % 5 == 0) b = b >> 20;
            run_op(1'b0, op, a, b, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs_res !== e.res || obs_zero !== e.zero || obs_lat != e.lat) begin
                n_fail++;
                $display("FAIL b2b_op%0d op=%b a=%h b=%h: got res=%h zero=%b lat=%0d, want res=%h zero=%b lat=%0d",
                         i, op, a, b, obs_res, obs_zero, obs_lat, e.res, e.zero, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_reset_mid_op();
        test_width8();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the combinational datapath ALU. It adds iterative unsigned multiply and divide/remainder to the existing logic/arithmetic op set.
- Operands are accepted through a start/ready handshake. Results are returned with a one-cycle valid_out pulse.
- Single-cycle ops finish in 1 cycle; multiply/divide take WIDTH+1 cycles.
- Sits in the execute stage of the multi-cycle core, replacing the combinational ALU.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values ≥ 4; counter width is derived internally as clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- A  input  WIDTH  operand A; sampled on accepted start
- B  input  WIDTH  operand B; sampled on accepted start
- ALUControl_in  input  4  operation code; sampled on accepted start
- ready  output  1  high only in IDLE
- valid_out  output  1  one-cycle pulse; ALU_result and zero are valid
- ALU_result  output  WIDTH  registered result; held until the next completion
- zero  output  1  registered flag; held with ALU_result

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, ready=1, valid_out=0, ALU_result=0, zero=0, counter=0, internal accumulators=0.
- Opcodes, single-cycle ops:
  - 0000 AND
  - 0001 OR
  - 0010 ADD, modulo 2^WIDTH
  - 0110 SUB, modulo 2^WIDTH; zero=(A==B)
  - 0111 SLTU, unsigned; result=(A<B), zero=(A<B)
  - 1100 NOR
  - any other unlisted code: result=A
- Opcodes, multi-cycle ops:
  - 1000 MUL, low WIDTH bits of A*B
  - 1001 MULHU, high WIDTH bits of the unsigned 2*WIDTH-bit product
  - 1010 DIVU, unsigned quotient
  - 1011 REMU, unsigned remainder
- zero=0 for every op except SUB and SLTU.
- FSM states: IDLE, BUSY, DONE.
  - IDLE & start & single-cycle op → DONE. The result is computed from the sampled operands and registered on entry to DONE.
  - IDLE & start & multi-cycle op → BUSY. Operands are latched and counter=0.
  - BUSY: one iteration per cycle.
    - Multiply: shift-add, 2*WIDTH-bit accumulator.
    - Divide: restoring, WIDTH-bit partial remainder.
    - On the cycle the counter reaches WIDTH-1 → DONE, with the result registered.
  - DONE: valid_out=1 for exactly one cycle, ready=0 → IDLE unconditionally.
- Latency, from the accepting edge to the edge at which valid_out goes high:
  - single-cycle ops: 1 cycle
  - multi-cycle ops: WIDTH+1 cycles
- The next start can be accepted in the cycle after DONE; maximum throughput is one op per 2 cycles for single-cycle ops.
- start while ready=0 (BUSY or DONE) is ignored with no side effects. A/B/ALUControl_in changes during BUSY have no effect.
- Divide by zero (RISC-V semantics): DIVU → all ones (2^WIDTH-1); REMU → A. No trap; same latency.
- A=0 or B=0 multiply still takes the full WIDTH+1 cycles. There is no early termination.
- ALU_result and zero change only on entry to DONE or on reset.
- Reset asserted mid-BUSY or in DONE: immediate return to the reset values; the pending op is discarded; no valid_out.

Test Plan:
- Reset, then ADD 5+7 → valid_out 1 cycle after accept, ALU_result=12, zero=0, ready back to 1 the following cycle.
- SUB 9-9 → ALU_result=0, zero=1. SUB 3-5 → 0xFFFFFFFE, zero=0. SLTU 3,5 → 1, zero=1. Code 1111 with A=0xABCD → 0xABCD.
- MUL 0xFFFFFFFF*2 → 0xFFFFFFFE and MULHU of the same operands → 0x00000001, each with valid_out exactly 33 cycles after accept. start pulses during BUSY are ignored and the result is unchanged.
- DIVU 100/7 → 14 and REMU 100/7 → 2. DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, both at 33-cycle latency.
- Reset asserted at cycle 10 of a DIVU → ready=1, valid_out=0, ALU_result=0 immediately; no valid_out pulse follows. A new ADD 1+1 then completes normally → 2.
- WIDTH=8 instance: MULHU 0xFF*0xFF → 0xFE; DIVU 0xFF/0x10 → 0x0F; latency 9 cycles.
